// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO operand port.
// Holds register offsets (word index within the 16-byte window), STATUS bit
// positions and the default window base address.
package mmio_pkg;

  localparam logic [1:0] OFF_STATUS   = 2'd0;
  localparam logic [1:0] OFF_OPERANDS = 2'd1;
  localparam logic [1:0] OFF_RESULT   = 2'd2;

  localparam int ST_OPR_VALID    = 0;
  localparam int ST_RESULT_VALID = 1;
  localparam int ST_OVERFLOW     = 2;
  localparam int ST_IRQ_MASK     = 3;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_1000;

endpackage

// File: rtl/mmio_operand_port_sync_edge.sv
// sync_edge: multi-flop synchronizer for asynchronous inputs.
// Parameters:
//   WIDTH       - number of independent bits synchronized in parallel
//   SYNC_STAGES - flop depth of the synchronizer chain (>= 2)
//   EDGE        - 0: out_o is the synchronized level
//                 1: out_o is a one-cycle pulse per synchronized rising edge
// Ports:
//   clk, resetn  - clock, asynchronous active-low reset
//   d_i          - asynchronous input bits
//   out_o        - synchronized level or rising-edge pulse (see EDGE)
module sync_edge #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE        = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] out_o
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];

  always_comb begin
    sync_d[0] = d_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  generate
    if (EDGE) begin : g_edge
      // Previous synchronized value; a held-high input yields a single pulse.
      logic [WIDTH-1:0] prev_q;
      logic [WIDTH-1:0] prev_d;

      always_comb prev_d = sync_q[SYNC_STAGES-1];

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) prev_q <= '0;
        else         prev_q <= prev_d;
      end

      assign out_o = sync_q[SYNC_STAGES-1] & ~prev_q;
    end else begin : g_level
      assign out_o = sync_q[SYNC_STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/mmio_operand_port.sv
// mmio_operand_port: memory-mapped responder bridging the CPU data bus and
// the external operator (switch operands in, 16-bit result out).
// Optional feature macro: MMIO_OPERAND_IRQ_EN (adds irq output and the
// STATUS IRQ_MASK bit).
// Ports:
//   clk, resetn         - clock, asynchronous active-low reset
//   bus_addr/we/wdata   - CPU data-bus request (byte address)
//   bus_rdata           - combinational read data, 0 when not hit
//   bus_hit             - address falls inside the 16-byte window
//   opr1, opr2          - asynchronous operand switches
//   opr_strobe          - asynchronous capture button
//   result, result_valid- last result written by software, pending flag
//   result_ack          - asynchronous operator acknowledge
//   irq                 - (MMIO_OPERAND_IRQ_EN only) registered flag interrupt
// Register map (offset): 0x0 STATUS, 0x4 OPERANDS, 0x8 RESULT, 0xC reserved.
module mmio_operand_port
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] bus_addr,
  input  logic        bus_we,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_hit,
  input  logic [7:0]  opr1,
  input  logic [7:0]  opr2,
  input  logic        opr_strobe,
  output logic [15:0] result,
  output logic        result_valid,
  input  logic        result_ack
`ifdef MMIO_OPERAND_IRQ_EN
  ,
  output logic        irq
`endif
);

  logic [1:0]  offset;
  logic        wr_status;
  logic        wr_result;
  logic [15:0] opr_sync;
  logic [1:0]  ctl_pulse;
  logic        strobe_pulse;
  logic        ack_pulse;
  logic [31:0] status_rd;

  logic        opr_valid_q,    opr_valid_d;
  logic        overflow_q,     overflow_d;
  logic [7:0]  opr1_lat_q,     opr1_lat_d;
  logic [7:0]  opr2_lat_q,     opr2_lat_d;
  logic [15:0] result_q,       result_d;
  logic        result_valid_q, result_valid_d;

  sync_edge #(
    .WIDTH       (16),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE        (1'b0)
  ) u_opr_sync (
    .clk    (clk),
    .resetn (resetn),
    .d_i    ({opr2, opr1}),
    .out_o  (opr_sync)
  );

  sync_edge #(
    .WIDTH       (2),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE        (1'b1)
  ) u_ctl_sync (
    .clk    (clk),
    .resetn (resetn),
    .d_i    ({result_ack, opr_strobe}),
    .out_o  (ctl_pulse)
  );

  assign strobe_pulse = ctl_pulse[0];
  assign ack_pulse    = ctl_pulse[1];

  assign bus_hit   = (bus_addr[31:4] == BASE_ADDR[31:4]);
  assign offset    = bus_addr[3:2];
  assign wr_status = bus_we && bus_hit && (offset == OFF_STATUS);
  assign wr_result = bus_we && bus_hit && (offset == OFF_RESULT);

`ifdef MMIO_OPERAND_IRQ_EN
  logic irq_mask_q, irq_mask_d;
  logic irq_q,      irq_d;

  always_comb begin
    irq_mask_d = irq_mask_q;
    if (wr_status) irq_mask_d = bus_wdata[ST_IRQ_MASK];
    irq_d = irq_mask_q & (opr_valid_q | overflow_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq_mask_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      irq_mask_q <= irq_mask_d;
      irq_q      <= irq_d;
    end
  end

  assign irq = irq_q;

  logic unused_bits;
  assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:16], bus_wdata[ST_RESULT_VALID]};
`else
  logic unused_bits;
  assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:16], bus_wdata[ST_IRQ_MASK],
                         bus_wdata[ST_RESULT_VALID]};
`endif

  always_comb begin
    status_rd                  = 32'b0;
    status_rd[ST_OPR_VALID]    = opr_valid_q;
    status_rd[ST_RESULT_VALID] = result_valid_q;
    status_rd[ST_OVERFLOW]     = overflow_q;
`ifdef MMIO_OPERAND_IRQ_EN
    status_rd[ST_IRQ_MASK]     = irq_mask_q;
`endif
  end

  always_comb begin
    bus_rdata = 32'b0;
    if (bus_hit) begin
      case (offset)
        OFF_STATUS:   bus_rdata = status_rd;
        OFF_OPERANDS: bus_rdata = {16'b0, opr2_lat_q, opr1_lat_q};
        OFF_RESULT:   bus_rdata = {16'b0, result_q};
        default:      bus_rdata = 32'b0;
      endcase
    end
  end

  always_comb begin
    opr_valid_d    = opr_valid_q;
    overflow_d     = overflow_q;
    opr1_lat_d     = opr1_lat_q;
    opr2_lat_d     = opr2_lat_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;

    // Software clears are applied before the capture so that a strobe in the
    // same cycle as an opr_valid clear is accepted rather than overflowing.
    if (wr_status && bus_wdata[ST_OPR_VALID]) opr_valid_d = 1'b0;
    if (wr_status && bus_wdata[ST_OVERFLOW])  overflow_d  = 1'b0;

    if (strobe_pulse) begin
      if (!opr_valid_d) begin
        opr1_lat_d  = opr_sync[7:0];
        opr2_lat_d  = opr_sync[15:8];
        opr_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end

    // A RESULT write wins over a coincident acknowledge.
    if (ack_pulse) result_valid_d = 1'b0;
    if (wr_result) begin
      result_d       = bus_wdata[15:0];
      result_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      opr_valid_q    <= 1'b0;
      overflow_q     <= 1'b0;
      opr1_lat_q     <= 8'h00;
      opr2_lat_q     <= 8'h00;
      result_q       <= 16'h0000;
      result_valid_q <= 1'b0;
    end else begin
      opr_valid_q    <= opr_valid_d;
      overflow_q     <= overflow_d;
      opr1_lat_q     <= opr1_lat_d;
      opr2_lat_q     <= opr2_lat_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_mmio_operand_port.sv
// Directed self-checking bench for mmio_operand_port (default parameters).
module tb_mmio_operand_port;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] A_STATUS   = BASE + 32'h0;
  localparam logic [31:0] A_OPERANDS = BASE + 32'h4;
  localparam logic [31:0] A_RESULT   = BASE + 32'h8;
  localparam logic [31:0] A_RSVD     = BASE + 32'hC;

  logic        clk;
  logic        resetn;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_hit;
  logic [7:0]  opr1;
  logic [7:0]  opr2;
  logic        opr_strobe;
  logic [15:0] result;
  logic        result_valid;
  logic        result_ack;
`ifdef MMIO_OPERAND_IRQ_EN
  logic        irq;
`endif

  int checks;
  int failures;

  mmio_operand_port dut (
    .clk          (clk),
    .resetn       (resetn),
    .bus_addr     (bus_addr),
    .bus_we       (bus_we),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_hit      (bus_hit),
    .opr1         (opr1),
    .opr2         (opr2),
    .opr_strobe   (opr_strobe),
    .result       (result),
    .result_valid (result_valid),
    .result_ack   (result_ack)
`ifdef MMIO_OPERAND_IRQ_EN
    ,
    .irq          (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges, landing 1ns after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    bus_addr = addr;
    bus_we   = 1'b0;
    #1;
    data = bus_rdata;
  endtask

  // Write committed on the next rising edge.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus_addr  = addr;
    bus_wdata = data;
    bus_we    = 1'b1;
    @(posedge clk);
    #1;
    bus_we    = 1'b0;
    bus_wdata = 32'h0;
  endtask

  task automatic pulse_strobe();
    opr_strobe = 1'b1;
    tick(4);
    opr_strobe = 1'b0;
    tick(4);
  endtask

  task automatic pulse_ack();
    result_ack = 1'b1;
    tick(4);
    result_ack = 1'b0;
    tick(4);
  endtask

  logic [31:0] rd;

  initial begin
    checks     = 0;
    failures   = 0;
    resetn     = 1'b0;
    bus_addr   = 32'h0;
    bus_we     = 1'b0;
    bus_wdata  = 32'h0;
    opr1       = 8'h00;
    opr2       = 8'h00;
    opr_strobe = 1'b0;
    result_ack = 1'b0;

    // Reset
    #13;
    check_eq("rst_result", {16'h0, result}, 32'h0);
    check_eq("rst_result_valid", {31'h0, result_valid}, 32'h0);
`ifdef MMIO_OPERAND_IRQ_EN
    check_eq("rst_irq", {31'h0, irq}, 32'h0);
`endif
    bus_read(A_STATUS, rd);
    check_eq("rst_status", rd, 32'h0);
    check_eq("rst_hit", {31'h0, bus_hit}, 32'h1);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    tick(2);
    bus_read(A_STATUS, rd);
    check_eq("post_rst_status", rd, 32'h0);
    bus_read(A_OPERANDS, rd);
    check_eq("post_rst_operands", rd, 32'h0);

    // Capture with latency check
    opr1 = 8'h12;
    opr2 = 8'h34;
    opr_strobe = 1'b1;
    tick(2);
    bus_read(A_STATUS, rd);
    check_eq("cap_status_early", rd, 32'h0);
    tick(1);
    bus_read(A_STATUS, rd);
    check_eq("cap_status", rd, 32'h1);
    bus_read(A_OPERANDS, rd);
    check_eq("cap_operands", rd, 32'h0000_3412);
    tick(2);
    opr_strobe = 1'b0;
    tick(4);
    bus_write(A_STATUS, 32'h1);
    bus_read(A_STATUS, rd);
    check_eq("cap_clear", rd, 32'h0);

    // Overflow
    opr1 = 8'h01;
    opr2 = 8'h02;
    pulse_strobe();
    opr1 = 8'hFF;
    opr2 = 8'hFF;
    pulse_strobe();
    bus_read(A_OPERANDS, rd);
    check_eq("ovf_operands", rd, 32'h0000_0201);
    bus_read(A_STATUS, rd);
    check_eq("ovf_status", rd, 32'h5);
    bus_write(A_STATUS, 32'h4);
    bus_read(A_STATUS, rd);
    check_eq("ovf_clear", rd, 32'h1);
    bus_write(A_STATUS, 32'h1);
    bus_read(A_STATUS, rd);
    check_eq("ovf_clear_valid", rd, 32'h0);

`ifndef MMIO_OPERAND_IRQ_EN
    bus_write(A_STATUS, 32'h8);
    bus_read(A_STATUS, rd);
    check_eq("mask_absent", rd, 32'h0);
`endif

    // Result handshake
    bus_write(A_RESULT, 32'hABCD_BEEF);
    check_eq("res_value", {16'h0, result}, 32'h0000_BEEF);
    check_eq("res_valid", {31'h0, result_valid}, 32'h1);
    bus_read(A_RESULT, rd);
    check_eq("res_read", rd, 32'h0000_BEEF);
    bus_read(A_STATUS, rd);
    check_eq("res_status", rd, 32'h2);
    pulse_ack();
    check_eq("res_acked", {31'h0, result_valid}, 32'h0);
    check_eq("res_kept", {16'h0, result}, 32'h0000_BEEF);

    // Ack edge coincident with RESULT write
    bus_write(A_RESULT, 32'h11);
    result_ack = 1'b1;
    tick(2);
    bus_write(A_RESULT, 32'h42);
    check_eq("col_ack_valid", {31'h0, result_valid}, 32'h1);
    check_eq("col_ack_result", {16'h0, result}, 32'h0000_0042);
    tick(5);
    check_eq("held_ack_single", {31'h0, result_valid}, 32'h1);
    result_ack = 1'b0;
    tick(4);

    // Strobe coincident with W1C of opr_valid
    opr1 = 8'h55;
    opr2 = 8'h66;
    pulse_strobe();
    opr1 = 8'h77;
    opr2 = 8'h88;
    opr_strobe = 1'b1;
    tick(2);
    bus_write(A_STATUS, 32'h1);
    bus_read(A_STATUS, rd);
    check_eq("col_strobe_status", rd, 32'h3);
    bus_read(A_OPERANDS, rd);
    check_eq("col_strobe_operands", rd, 32'h0000_8877);
    opr_strobe = 1'b0;
    tick(4);

    // Decode
    bus_read(BASE + 32'h10, rd);
    check_eq("dec_hi_rdata", rd, 32'h0);
    check_eq("dec_hi_hit", {31'h0, bus_hit}, 32'h0);
    bus_read(BASE - 32'h4, rd);
    check_eq("dec_lo_rdata", rd, 32'h0);
    check_eq("dec_lo_hit", {31'h0, bus_hit}, 32'h0);
    bus_write(BASE + 32'h10, 32'h5);
    bus_write(BASE + 32'h18, 32'h99);
    bus_write(BASE - 32'h4, 32'h77);
    bus_read(A_STATUS, rd);
    check_eq("dec_status_kept", rd, 32'h3);
    check_eq("dec_result_kept", {16'h0, result}, 32'h0000_0042);
    bus_read(A_RSVD, rd);
    check_eq("rsvd_read", rd, 32'h0);

    // Held strobe: one capture only
    bus_write(A_STATUS, 32'h1);
    opr1 = 8'hAA;
    opr2 = 8'hBB;
    opr_strobe = 1'b1;
    tick(20);
    opr_strobe = 1'b0;
    tick(4);
    bus_read(A_STATUS, rd);
    check_eq("held_strobe_status", rd, 32'h3);
    bus_read(A_OPERANDS, rd);
    check_eq("held_strobe_operands", rd, 32'h0000_BBAA);

    // Reset mid-handshake
    #2;
    resetn = 1'b0;
    #1;
    check_eq("mid_rst_valid", {31'h0, result_valid}, 32'h0);
    check_eq("mid_rst_result", {16'h0, result}, 32'h0);
    bus_read(A_STATUS, rd);
    check_eq("mid_rst_status", rd, 32'h0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    tick(4);
    bus_read(A_STATUS, rd);
    check_eq("post_mid_rst_status", rd, 32'h0);
    bus_read(A_OPERANDS, rd);
    check_eq("post_mid_rst_operands", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
